bit_deser: RTL and testbench

BIT_DESER -- requirements
Module: bit_deser

---
 rtl/bit_deser_pkg.sv | 23 ++
 rtl/deser_fifo2.sv | 81 ++++++++
 rtl/bit_deser.sv | 122 ++++++++++++
 tb/tb_bit_deser.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/bit_deser_pkg.sv
// Shared types and widths for the serial bit deserializer.
package bit_deser_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned TS_W       = 32;
    localparam int unsigned REC_W      = BYTE_W + TS_W;
    localparam int unsigned BIT_CNT_W  = 4;
    localparam int unsigned BYTE_CNT_W = 8;

    localparam logic [BYTE_W-1:0] DEF_SYNC_WORD = 8'hA5;

    typedef enum logic {
        HUNT = 1'b0,
        DATA = 1'b1
    } state_t;

    // One assembled byte together with the cycle stamp of its last bit.
    typedef struct packed {
        logic [BYTE_W-1:0] data;
        logic [TS_W-1:0]   ts;
    } byte_rec_t;

endpackage

// File: rtl/deser_fifo2.sv
// Two-entry FIFO with valid/ready on both sides; head entry drives the outputs.
module deser_fifo2 #(
    parameter int unsigned W = 40
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready_c,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         full
);

    logic [W-1:0] head_q, head_n;
    logic [W-1:0] tail_q, tail_n;
    logic [1:0]   cnt_q, cnt_n;
    logic         push_c;
    logic         pop_c;

    // A full FIFO can still take a new entry when the head leaves this cycle.
    assign in_ready_c = (cnt_q != 2'd2) || out_ready;
    assign push_c     = in_valid && in_ready_c;
    assign pop_c      = out_valid && out_ready;

    // Next-state for the head/tail registers and occupancy.
    always_comb begin
        head_n = head_q;
        tail_n = tail_q;
        cnt_n  = cnt_q;
        case (cnt_q)
            2'd0: begin
                if (push_c) begin
                    head_n = in_data;
                    cnt_n  = 2'd1;
                end
            end
            2'd1: begin
                if (push_c && pop_c) begin
                    head_n = in_data;
                end else if (push_c) begin
                    tail_n = in_data;
                    cnt_n  = 2'd2;
                end else if (pop_c) begin
                    cnt_n  = 2'd0;
                end
            end
            default: begin
                if (pop_c) begin
                    head_n = tail_q;
                    if (push_c) begin
                        tail_n = in_data;
                    end else begin
                        cnt_n  = 2'd1;
                    end
                end
            end
        endcase
    end

    // Storage and registered status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            cnt_q     <= 2'd0;
            out_valid <= 1'b0;
            full      <= 1'b0;
        end else begin
            head_q    <= head_n;
            tail_q    <= tail_n;
            cnt_q     <= cnt_n;
            out_valid <= (cnt_n != 2'd0);
            full      <= (cnt_n == 2'd2);
        end
    end

    assign out_data = head_q;

endmodule

// File: rtl/bit_deser.sv
// Serial-to-byte deserializer: hunts for a sync word, then frames fixed-length payloads.
module bit_deser
    import bit_deser_pkg::*;
#(
    parameter logic [BYTE_W-1:0] SYNC_WORD   = DEF_SYNC_WORD,
    parameter int unsigned       FRAME_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_in,
    output logic [BYTE_W-1:0] byte_data,
    output logic [TS_W-1:0]   byte_ts,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              sync_lock,
    output logic              overflow
);

    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(FRAME_BYTES - 1);

    state_t                  state_q, state_n;
    // Only the low 7 bits are kept; the post-shift byte is {shift_q, bit_in}.
    logic [BYTE_W-2:0]       shift_q, shift_n;
    logic [BYTE_W-1:0]       shift_post_c;
    logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_n;
    logic [BYTE_CNT_W-1:0]   byte_cnt_q, byte_cnt_n;
    logic [TS_W-1:0]         ts_q;
    logic                    push_c;
    logic                    drop_c;
    logic                    fifo_in_ready_c;
    logic                    fifo_full;
    byte_rec_t               rec_in_c;
    byte_rec_t               rec_out;

    assign shift_post_c = {shift_q, bit_in};

    // Framing FSM: next state, counters and FIFO push.
    always_comb begin
        state_n    = state_q;
        shift_n    = shift_post_c[BYTE_W-2:0];
        bit_cnt_n  = bit_cnt_q;
        byte_cnt_n = byte_cnt_q;
        push_c     = 1'b0;
        case (state_q)
            HUNT: begin
                if (bit_cnt_q != BIT_CNT_W'(8)) begin
                    bit_cnt_n = BIT_CNT_W'(bit_cnt_q + BIT_CNT_W'(1));
                end
                // bit_cnt_q >= 7 means this bit is at least the 8th since hunting began.
                if ((shift_post_c == SYNC_WORD) && (bit_cnt_q >= BIT_CNT_W'(7))) begin
                    state_n    = DATA;
                    bit_cnt_n  = '0;
                    byte_cnt_n = '0;
                end
            end
            DATA: begin
                if (bit_cnt_q == BIT_CNT_W'(7)) begin
                    push_c    = 1'b1;
                    bit_cnt_n = '0;
                    if (byte_cnt_q == LAST_BYTE) begin
                        state_n    = HUNT;
                        shift_n    = '0;
                        byte_cnt_n = '0;
                    end else begin
                        byte_cnt_n = BYTE_CNT_W'(byte_cnt_q + BYTE_CNT_W'(1));
                    end
                end else begin
                    bit_cnt_n = BIT_CNT_W'(bit_cnt_q + BIT_CNT_W'(1));
                end
            end
            default: begin
                state_n = HUNT;
            end
        endcase
    end

    // Only a full FIFO can refuse a byte; the frame keeps advancing regardless.
    assign drop_c = push_c && fifo_full && !fifo_in_ready_c;

    // State, counters, timestamp and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            ts_q       <= '0;
            sync_lock  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state_q    <= state_n;
            shift_q    <= shift_n;
            bit_cnt_q  <= bit_cnt_n;
            byte_cnt_q <= byte_cnt_n;
            ts_q       <= TS_W'(ts_q + TS_W'(1));
            sync_lock  <= (state_n == DATA);
            overflow   <= overflow || drop_c;
        end
    end

    assign rec_in_c.data = shift_post_c;
    assign rec_in_c.ts   = ts_q;

    // Output queue decoupling the framer from the consumer.
    deser_fifo2 #(
        .W (REC_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (push_c),
        .in_ready_c (fifo_in_ready_c),
        .in_data    (rec_in_c),
        .out_valid  (byte_valid),
        .out_ready  (byte_ready),
        .out_data   (rec_out),
        .full       (fifo_full)
    );

    assign byte_data = rec_out.data;
    assign byte_ts   = rec_out.ts;

endmodule

// File: tb/tb_bit_deser.sv
// Randomized bench for bit_deser against a queue-based frame/FIFO reference model.
module tb_bit_deser;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         FB   = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bit_in;
    logic        byte_ready;
    logic [7:0]  byte_data;
    logic [31:0] byte_ts;
    logic        byte_valid;
    logic        sync_lock;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit          hunt[$];
    bit          dbits[$];
    bit          m_locked;
    bit          m_ovf;
    int          m_nbytes;
    logic [31:0] m_ts;
    logic [39:0] mq[$];

    bit_deser #(.SYNC_WORD(SYNC), .FRAME_BYTES(FB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_in     (bit_in),
        .byte_data  (byte_data),
        .byte_ts    (byte_ts),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .sync_lock  (sync_lock),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] bits_val(input bit q[$]);
        logic [7:0] v = 8'h00;
        foreach (q[i]) v = 8'((v << 1) | 8'(q[i]));
        return v;
    endfunction

    // One clock edge of the reference: framing rules, then a 2-deep output queue.
    function automatic void model_edge(input bit b, input bit rdy, input bit rst);
        logic [31:0] ts_now;
        logic [7:0]  val;
        bit          have;
        bit          pop;
        if (rst) begin
            hunt.delete(); dbits.delete(); mq.delete();
            m_locked = 0; m_ovf = 0; m_nbytes = 0; m_ts = 32'd0;
            return;
        end
        ts_now = m_ts;
        m_ts   = m_ts + 32'd1;
        pop    = (mq.size() != 0) && rdy;
        have   = 0;
        val    = 8'h00;
        if (!m_locked) begin
            hunt.push_back(b);
            if (hunt.size() > 8) void'(hunt.pop_front());
            if (hunt.size() == 8 && bits_val(hunt) == SYNC) begin
                m_locked = 1; m_nbytes = 0; dbits.delete();
            end
        end else begin
            dbits.push_back(b);
            if (dbits.size() == 8) begin
                val  = bits_val(dbits);
                have = 1;
                dbits.delete();
                m_nbytes++;
                if (m_nbytes == FB) begin
                    m_locked = 0; hunt.delete();
                end
            end
        end
        if (have && mq.size() == 2 && !pop) begin
            m_ovf = 1;
        end else begin
            if (pop) void'(mq.pop_front());
            if (have) mq.push_back({val, ts_now});
        end
    endfunction

    task automatic step(input logic b, input logic rdy, input logic rst);
        bit_in     = b;
        byte_ready = rdy;
        rst_n      = ~rst;
        @(posedge clk);
        model_edge(b, rdy, rst);
        #1;
        check("valid", 32'(byte_valid), 32'(mq.size() != 0));
        check("lock", 32'(sync_lock), 32'(m_locked));
        check("ovf", 32'(overflow), 32'(m_ovf));
        if (mq.size() != 0) begin
            check("data", 32'(byte_data), 32'(mq[0][39:32]));
            check("ts", byte_ts, mq[0][31:0]);
        end
        if (rst) begin
            check("rst_data", 32'(byte_data), 32'd0);
            check("rst_ts", byte_ts, 32'd0);
        end
    endtask

    // rmode: 0 = ready low, 1 = ready high, 2 = random ready per bit
    task automatic send_byte(input logic [7:0] v, input int rmode);
        for (int i = 7; i >= 0; i--) begin
            step(v[i], (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'(rmode), 1'b0);
        end
    endtask

    task automatic do_reset();
        repeat (2) step(1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        logic [7:0]  pay[4];
        logic [31:0] prev_ts;
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
        bit_in = 1'b0; byte_ready = 1'b1; rst_n = 1'b0;
        do_reset();

        // Basic frame with ready held high
        send_byte(SYNC, 1);
        check("basic_lock", 32'(sync_lock), 32'd1);
        prev_ts = 32'd0;
        for (int k = 0; k < 4; k++) begin
            send_byte(pay[k], 1);
            check("basic_valid", 32'(byte_valid), 32'd1);
            check("basic_byte", 32'(byte_data), 32'(pay[k]));
            if (k > 0) check("basic_ts_step", byte_ts - prev_ts, 32'd8);
            prev_ts = byte_ts;
        end
        check("basic_unlock", 32'(sync_lock), 32'd0);
        repeat (4) step(1'b0, 1'b1, 1'b0);

        // False sync, then a payload byte equal to the sync word
        do_reset();
        send_byte(8'hA4, 1);
        check("false_nolock", 32'(sync_lock), 32'd0);
        send_byte(SYNC, 1);
        check("false_lock", 32'(sync_lock), 32'd1);
        send_byte(SYNC, 1);
        check("sync_as_data", 32'(byte_data), 32'(SYNC));
        check("no_resync", 32'(sync_lock), 32'd1);
        send_byte(8'h5A, 1); send_byte(8'hC3, 1); send_byte(8'h0F, 1);
        repeat (3) step(1'b0, 1'b1, 1'b0);

        // Backpressure through a full frame
        do_reset();
        send_byte(SYNC, 1);
        for (int k = 0; k < 4; k++) send_byte(pay[k], 0);
        check("bp_ovf", 32'(overflow), 32'd1);
        check("bp_head", 32'(byte_data), 32'h11);
        repeat (4) step(1'b0, 1'b1, 1'b0);
        check("bp_drained", 32'(byte_valid), 32'd0);
        check("bp_ovf_sticky", 32'(overflow), 32'd1);

        // Full FIFO with a pop on the cycle byte 3 completes
        do_reset();
        send_byte(SYNC, 1);
        send_byte(pay[0], 0);
        send_byte(pay[1], 0);
        for (int i = 7; i >= 1; i--) step(pay[2][i], 1'b0, 1'b0);
        step(pay[2][0], 1'b1, 1'b0);
        check("sim_noovf", 32'(overflow), 32'd0);
        send_byte(pay[3], 1);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        check("sim_noovf_end", 32'(overflow), 32'd0);

        // Reset after 12 payload bits, then no sync
        do_reset();
        send_byte(SYNC, 1);
        repeat (12) step(1'($urandom_range(0, 1)), 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        check("mid_rst_valid", 32'(byte_valid), 32'd0);
        check("mid_rst_lock", 32'(sync_lock), 32'd0);
        repeat (40) step(1'b0, 1'b1, 1'b0);
        check("mid_rst_quiet", 32'(byte_valid), 32'd0);

        // Timestamp wrap inside the first payload byte
        do_reset();
        send_byte(SYNC, 1);
        force dut.ts_q = 32'hFFFF_FFFE;
        #1;
        release dut.ts_q;
        m_ts = 32'hFFFF_FFFE;
        send_byte(pay[0], 1);
        check("wrap_ts", byte_ts, 32'h0000_0005);
        for (int k = 1; k < 4; k++) send_byte(pay[k], 1);
        repeat (3) step(1'b0, 1'b1, 1'b0);

        // Randomized frames with random gaps and random consumer stalls
        do_reset();
        repeat (60) begin
            repeat ($urandom_range(0, 12)) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            send_byte(SYNC, 2);
            repeat (FB) send_byte(8'($urandom), 2);
            if ($urandom_range(0, 19) == 0) step(1'b0, 1'b1, 1'b1);
        end
        repeat (4) step(1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
